instr_encoder: RTL
==================

Name: instr_encoder

Overview:
- Inverse of the immediate generator: packs decoded instruction fields (format, opcode, register indices, funct fields, 32-bit immediate) into a 32-bit RV32I instruction word.
- Used by the on-chip self-test sequencer and the debug instruction injector to build instructions that feed the fetch path.
- Valid/ready on both sides. Registered encode stage followed by a 2-entry output FIFO.
- Output is bit-exact with what immgen expects to decode.

Parameters:
- FIFO_DEPTH, 2, output buffer entries (power of two, ≥2)
- XLEN, 32, instruction/immediate width (only 32 supported)

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  field bundle valid
- in_ready  output  1  encoder can accept bundle
- in_fmt  input  3  0=R 1=I 2=S 3=B 4=U 5=J, 6/7 illegal
- in_opcode  input  7  opcode[6:0]
- in_rd  input  5  destination register
- in_rs1  input  5  source register 1
- in_rs2  input  5  source register 2
- in_funct3  input  3  funct3
- in_funct7  input  7  funct7 (R only)
- in_imm  input  32  immediate, sign-extended byte offset / value
- out_valid  output  1  instruction word valid
- out_ready  input  1  consumer accepts word
- out_instr  output  32  encoded instruction
- out_err  output  1  bundle was illegal / out of range
- enc_count  output  16  number of words popped, wraps at 0xFFFF→0

Behaviour:
- Reset (async assert, sync deassert by the driver): FIFO empty, out_valid=0, out_instr=0, out_err=0, enc_count=0, in_ready=0 while rst_n low, then 1.
- Accept when in_valid && in_ready. The encode stage is registered.
  - The word enters the FIFO at the next edge.
  - out_valid rises 1 cycle after acceptance if the FIFO was empty (latency 1).
- in_ready = (FIFO occupancy + stage occupancy) < FIFO_DEPTH, from registered state only. There is no combinational path from out_ready.
- Pop when out_valid && out_ready. enc_count increments on each pop.
- Simultaneous push and pop at full: the pop is honoured. The push is not taken because in_ready was 0.
- Simultaneous push and pop with one entry: occupancy unchanged, order preserved (strict FIFO).
- out_instr and out_err hold stable while out_valid && !out_ready.
- Encoding (opcode always in [6:0]):
  - R: f7 | rs2 | rs1 | f3 | rd
  - I: imm[11:0] | rs1 | f3 | rd
  - S: imm[11:5] | rs2 | rs1 | f3 | imm[4:0]
  - B: imm[12] | imm[10:5] | rs2 | rs1 | f3 | imm[4:1] | imm[11]
  - U: imm[31:12] | rd
  - J: imm[20] | imm[10:1] | imm[11] | imm[19:12] | rd
- Fields unused by a format are ignored.
- in_fmt 6/7: out_instr=0, out_err=1.
- Reset mid-operation: all entries discarded, enc_count cleared. No partial word is ever presented.

Optional Feature:
- Macro: IMM_RANGE_CHECK_EN.
- Defined: out_err=1 and out_instr is still encoded (truncated) when the immediate does not fit:
  - I/S: in_imm not the sign-extension of bit 11
  - B: not the sign-extension of bit 12, or bit 0 set
  - J: not the sign-extension of bit 20, or bit 0 set
  - U: in_imm[11:0]≠0
- Undefined: out_err only flags illegal in_fmt. Immediates are silently truncated.

Test Plan:
- I fmt, opcode 0000011, f3 010, rd=0, rs1=0, imm=0xFFFFFFFF → out_instr 0xFFF02003, out_err 0, out_valid 1 cycle after accept.
- S fmt, opcode 0100011, f3 010, rs1=0, rs2=1, imm=0xFFFFFFFE → 0xFE102F23.
- B fmt, opcode 1100011, f3 000, rs1=rs2=0, imm=0xFFFFFF0E → 0xF00007E3. Feed the result to immgen and confirm imm 0xFFFFFF0E.
- Backpressure:
  - Hold out_ready=0, push 3 bundles → in_ready drops after 2 are accepted (DEPTH=2), third stalls.
  - Release out_ready → words emerge in order, enc_count=3.
- in_fmt=7 → out_instr 0, out_err 1. With IMM_RANGE_CHECK_EN, B imm=0x1001 → out_err 1.
- Assert rst_n low with 2 entries queued → out_valid 0 and enc_count 0 immediately (async). The first word after release encodes correctly.

Source files
------------

// File: rtl/instr_encoder_if.sv
// Handshake/field bundle between a field producer (master) and the
// instruction encoder (slave).
interface instr_encoder_if #(
    parameter int XLEN = 32
);
    // Field bundle side
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      in_fmt;
    logic [6:0]      in_opcode;
    logic [4:0]      in_rd;
    logic [4:0]      in_rs1;
    logic [4:0]      in_rs2;
    logic [2:0]      in_funct3;
    logic [6:0]      in_funct7;
    logic [XLEN-1:0] in_imm;

    // Instruction word side
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_instr;
    logic            out_err;
    logic [15:0]     enc_count;

    modport master (
        output in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm, out_ready,
        input  in_ready, out_valid, out_instr, out_err, enc_count
    );

    modport slave (
        input  in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm, out_ready,
        output in_ready, out_valid, out_instr, out_err, enc_count
    );
endinterface

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs decoded fields into a 32-bit word.
// The encoded word is written straight into a small output FIFO on the
// accepting edge, so a word accepted into an empty FIFO is presented one
// cycle later. in_ready comes from registered occupancy only.
// Optional macro IMM_RANGE_CHECK_EN: also flag immediates that do not fit
// the selected format (the word is still encoded, truncated).
module instr_encoder #(
    parameter int FIFO_DEPTH = 2,
    parameter int XLEN       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    instr_encoder_if.slave   io_bus
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    if (XLEN != 32 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
        $error("instr_encoder: XLEN must be 32 and FIFO_DEPTH a power of two >= 2");
    end

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    logic [XLEN-1:0] w_instr;
    logic            w_err;
    logic            w_imm_bad;
    logic            w_push;
    logic            w_pop;
    logic [CW-1:0]   w_count_nxt;

    logic [XLEN:0]   r_mem [FIFO_DEPTH];   // {err, instr}
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            r_in_ready;
    logic [15:0]     r_enc_count;

    // Immediate range check: does in_imm fit the selected format?
`ifdef IMM_RANGE_CHECK_EN
    always_comb begin
        w_imm_bad = 1'b0;
        case (fmt_e'(io_bus.in_fmt))
            FMT_I, FMT_S: w_imm_bad = !((&io_bus.in_imm[31:11]) || !(|io_bus.in_imm[31:11]));
            FMT_B:        w_imm_bad = !((&io_bus.in_imm[31:12]) || !(|io_bus.in_imm[31:12]))
                                      || io_bus.in_imm[0];
            FMT_J:        w_imm_bad = !((&io_bus.in_imm[31:20]) || !(|io_bus.in_imm[31:20]))
                                      || io_bus.in_imm[0];
            FMT_U:        w_imm_bad = |io_bus.in_imm[11:0];
            default:      w_imm_bad = 1'b0;
        endcase
    end
`else
    assign w_imm_bad = 1'b0;
`endif

    // Field packing per instruction format
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        w_instr = '0;
        w_err   = w_imm_bad;
        case (fmt_e'(io_bus.in_fmt))
            FMT_R: w_instr = {io_bus.in_funct7, io_bus.in_rs2, io_bus.in_rs1,
                              io_bus.in_funct3, io_bus.in_rd, io_bus.in_opcode};
            FMT_I: w_instr = {io_bus.in_imm[11:0], io_bus.in_rs1,
                              io_bus.in_funct3, io_bus.in_rd, io_bus.in_opcode};
            FMT_S: w_instr = {io_bus.in_imm[11:5], io_bus.in_rs2, io_bus.in_rs1,
                              io_bus.in_funct3, io_bus.in_imm[4:0], io_bus.in_opcode};
            FMT_B: w_instr = {io_bus.in_imm[12], io_bus.in_imm[10:5], io_bus.in_rs2,
                              io_bus.in_rs1, io_bus.in_funct3, io_bus.in_imm[4:1],
                              io_bus.in_imm[11], io_bus.in_opcode};
            FMT_U: w_instr = {io_bus.in_imm[31:12], io_bus.in_rd, io_bus.in_opcode};
            FMT_J: w_instr = {io_bus.in_imm[20], io_bus.in_imm[10:1], io_bus.in_imm[11],
                              io_bus.in_imm[19:12], io_bus.in_rd, io_bus.in_opcode};
            default: begin
                w_instr = '0;
                w_err   = 1'b1;
            end
        endcase
    end

    assign w_push      = io_bus.in_valid && r_in_ready;
    assign w_pop       = (r_count != '0) && io_bus.out_ready;
    assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

    // Pointers, occupancy, registered in_ready and pop counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_in_ready  <= 1'b0;
            r_enc_count <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) begin
                r_rd_ptr    <= r_rd_ptr + 1'b1;
                r_enc_count <= r_enc_count + 16'd1;
            end
            r_count    <= w_count_nxt;
            r_in_ready <= (w_count_nxt < DEPTH_C);
        end
    end

    // FIFO storage write
    // NOTE: storage has no reset; entries are only visible while occupancy says valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= {w_err, w_instr};
    end

    assign io_bus.in_ready  = r_in_ready;
    assign io_bus.out_valid = (r_count != '0);
    assign io_bus.out_instr = io_bus.out_valid ? r_mem[r_rd_ptr][XLEN-1:0] : '0;
    assign io_bus.out_err   = io_bus.out_valid ? r_mem[r_rd_ptr][XLEN]     : 1'b0;
    assign io_bus.enc_count = r_enc_count;

endmodule
